latch_bank_ctrl: RTL

Write controller and arbiter for a bank of DEPTH level-sensitive D latches, each WIDTH bits wide. It shares the bank between NUM_REQ requesters with round-robin arbitration. For each write it sequences the latch gate: data setup, enable pulse, then data hold. It also drives the bank's active-low clear and sits between the requesting logic and the latch array.

---
 rtl/latch_bank_ctrl_if.sv | 32 +++
 rtl/latch_bank_ctrl.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/latch_bank_ctrl_if.sv
// Requester-side bus of the latch bank controller.
// Parameters must match the controller instance: AW = $clog2(DEPTH).
//   req       per-requester write request (level, held until ack)
//   req_addr  packed entry addresses, slice i belongs to requester i
//   req_data  packed write data, slice i belongs to requester i
//   clr       bank-clear request (level, held until clr_ack)
//   ack       one-cycle completion pulse to the granted requester
//   clr_ack   one-cycle pulse when a clear completes
//   err       one-cycle pulse alongside ack for an out-of-range address
interface latch_bank_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int AW      = 3,
    parameter int WIDTH   = 8
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*AW-1:0]    req_addr;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic                     clr;
    logic [NUM_REQ-1:0]       ack;
    logic                     clr_ack;
    logic                     err;

    modport master (
        output req, req_addr, req_data, clr,
        input  ack, clr_ack, err
    );

    modport slave (
        input  req, req_addr, req_data, clr,
        output ack, clr_ack, err
    );
endinterface

// File: rtl/latch_bank_ctrl.sv
// Write controller and round-robin arbiter for a bank of DEPTH level-sensitive
// D latches, WIDTH bits each, shared by NUM_REQ requesters. Each write walks
// the latch gate through data setup, a one-cycle enable pulse and data hold.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset (also clears the latch bank)
//   bus        requester bus (req/req_addr/req_data/clr in, ack/clr_ack/err out)
//   busy       high whenever the FSM is not in IDLE
//   grant_id   current or last granted requester
//   lat_en     one-hot latch gate, one bit per entry
//   lat_d      data to every latch d input
//   lat_rst_n  active-low clear to every latch
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | arbitrate; clr beats req; lat_d keeps its last value
// S_SETUP  | lat_d driven with captured data, gate closed
// S_ENABLE | gate of the addressed entry open (stays closed if out of range)
// S_HOLD   | gate closed, data held, ack (and err) pulsed
// S_CLR    | lat_rst_n low, clr_ack pulsed
module latch_bank_ctrl #(
    parameter  int NUM_REQ = 4,
    parameter  int DEPTH   = 8,
    parameter  int WIDTH   = 8,
    localparam int AW      = $clog2(DEPTH),
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    latch_bank_ctrl_if.slave      bus,
    output logic                  busy,
    output logic [GW-1:0]         grant_id,
    output logic [DEPTH-1:0]      lat_en,
    output logic [WIDTH-1:0]      lat_d,
    output logic                  lat_rst_n
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ENABLE,
        S_HOLD,
        S_CLR
    } state_t;

    state_t             state, state_nxt;
    logic               rst_done;
    logic [AW-1:0]      addr_q, addr_nxt;
    logic [GW-1:0]      gid_nxt;
    logic [NUM_REQ-1:0] ack_q, ack_nxt;
    logic               clr_ack_q, clr_ack_nxt;
    logic               err_q, err_nxt;
    logic               busy_nxt;
    logic [DEPTH-1:0]   lat_en_nxt;
    logic [WIDTH-1:0]   lat_d_nxt;
    logic               lat_rst_n_nxt;
    logic               addr_bad;
    logic               found;
    logic [GW-1:0]      pick;

    assign bus.ack     = ack_q;
    assign bus.clr_ack = clr_ack_q;
    assign bus.err     = err_q;

    // AW can cover more codes than DEPTH when DEPTH is not a power of two.
    assign addr_bad = (int'(addr_q) >= DEPTH);

    // Round-robin search starting just after the last grant; the last
    // granted requester is examined last.
    always_comb begin
        found = 1'b0;
        pick  = grant_id;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && bus.req[(int'(grant_id) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = GW'((int'(grant_id) + k) % NUM_REQ);
            end
        end
    end

    // Output values are computed for the state being entered, so every
    // output is a flop that reflects the current state directly.
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr_q;
        gid_nxt       = grant_id;
        ack_nxt       = '0;
        clr_ack_nxt   = 1'b0;
        err_nxt       = 1'b0;
        lat_en_nxt    = '0;
        lat_d_nxt     = lat_d;
        lat_rst_n_nxt = 1'b1;
        case (state)
            S_IDLE: begin
                // The first edge after reset only releases lat_rst_n.
                if (rst_done) begin
                    if (bus.clr) begin
                        state_nxt     = S_CLR;
                        lat_rst_n_nxt = 1'b0;
                        clr_ack_nxt   = 1'b1;
                    end else if (found) begin
                        state_nxt = S_SETUP;
                        gid_nxt   = pick;
                        addr_nxt  = bus.req_addr[int'(pick)*AW +: AW];
                        lat_d_nxt = bus.req_data[int'(pick)*WIDTH +: WIDTH];
                    end
                end
            end
            S_SETUP: begin
                state_nxt = S_ENABLE;
                if (!addr_bad) begin
                    lat_en_nxt = {{(DEPTH-1){1'b0}}, 1'b1} << addr_q;
                end
            end
            S_ENABLE: begin
                state_nxt         = S_HOLD;
                ack_nxt[grant_id] = 1'b1;
                err_nxt           = addr_bad;
            end
            S_HOLD:  state_nxt = S_IDLE;
            S_CLR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        busy_nxt = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            rst_done  <= 1'b0;
            addr_q    <= '0;
            grant_id  <= GW'(NUM_REQ - 1);
            ack_q     <= '0;
            clr_ack_q <= 1'b0;
            err_q     <= 1'b0;
            busy      <= 1'b0;
            lat_en    <= '0;
            lat_d     <= '0;
            lat_rst_n <= 1'b0;
        end else begin
            state     <= state_nxt;
            rst_done  <= 1'b1;
            addr_q    <= addr_nxt;
            grant_id  <= gid_nxt;
            ack_q     <= ack_nxt;
            clr_ack_q <= clr_ack_nxt;
            err_q     <= err_nxt;
            busy      <= busy_nxt;
            lat_en    <= lat_en_nxt;
            lat_d     <= lat_d_nxt;
            lat_rst_n <= lat_rst_n_nxt;
        end
    end
endmodule
